// File: rtl/fir_decim_buf_if.sv
// Stream bundle for fir_decim_buf: decimator input side and FIFO output side.
interface fir_decim_buf_if #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Input side has no back-pressure: a sample is taken on every cycle with
  // Data_in_vld=1. Output side transfers when Data_out_vld && Data_out_rdy at
  // a rising edge; Data_out_vld never depends on Data_out_rdy.
  logic [DW-1:0] Data_in;
  logic          Data_in_vld;
  logic [DW-1:0] Data_out;
  logic          Data_out_vld;
  logic          Data_out_rdy;
  logic [CW-1:0] count;

  modport slave (
    input  Data_in, Data_in_vld, Data_out_rdy,
    output Data_out, Data_out_vld, count
  );

  modport master (
    output Data_in, Data_in_vld, Data_out_rdy,
    input  Data_out, Data_out_vld, count
  );
endinterface

// File: rtl/fir_decim_buf.sv
// Keeps one sample in DECIM from the FIR output and buffers it in a FWFT FIFO.
// Optional FIR_DECIM_OVF_EN adds a sticky overflow flag and a drop counter.
module fir_decim_buf #(
  parameter int DW    = 10,
  parameter int DECIM = 2,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  fir_decim_buf_if.slave  bus
`ifdef FIR_DECIM_OVF_EN
  ,
  output logic            ovf,
  output logic [7:0]      drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    PHASE_LAST = 4'(DECIM - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  logic [3:0]    phase;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [DW-1:0] mem [DEPTH];

  logic push_req;
  logic push_ok;
  logic pop;
  logic full;

  always_comb begin
    full     = (count_q == FULL_CNT);
    pop      = (count_q != '0) && bus.Data_out_rdy;
    push_req = bus.Data_in_vld && (phase == 4'd0);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (bus.Data_in_vld)
        phase <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; Data_out is gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !reset)
      mem[wr_ptr] <= bus.Data_in;
  end

  assign bus.Data_out_vld = (count_q != '0);
  assign bus.Data_out     = (count_q != '0) ? mem[rd_ptr] : '0;
  assign bus.count        = count_q;

`ifdef FIR_DECIM_OVF_EN
  logic drop;
  assign drop = push_req && !push_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_buf.sv
// Bench for fir_decim_buf: one DECIM=2 and one DECIM=1 instance share stimulus,
// each tracked by its own reference FIFO queue.
module tb_fir_decim_buf;
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [DW-1:0] q_t[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_decim_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus2 ();
  fir_decim_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus1 ();

`ifdef FIR_DECIM_OVF_EN
  logic       ovf2, ovf1;
  logic [7:0] dc2, dc1;
`endif

  fir_decim_buf #(.DW(DW), .DECIM(2), .DEPTH(DEPTH)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus2)
`ifdef FIR_DECIM_OVF_EN
    ,
    .ovf      (ovf2),
    .drop_cnt (dc2)
`endif
  );

  fir_decim_buf #(.DW(DW), .DECIM(1), .DEPTH(DEPTH)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus1)
`ifdef FIR_DECIM_OVF_EN
    ,
    .ovf      (ovf1),
    .drop_cnt (dc1)
`endif
  );

  // ---------------- scoreboard state ----------------
  q_t exp_q2;
  q_t exp_q1;
  int ph[2];
  int drops[2];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance reference model sel (0: DECIM=2, 1: DECIM=1) for the inputs
  // about to be clocked; a pop compares the DUT head with the queue front.
  task automatic m_step(input int sel, input logic [DW-1:0] obs_out,
                        input logic vld, input logic [DW-1:0] d, input logic rdy);
    q_t            q;
    logic [DW-1:0] head;
    bit            pop, full, req;
    int            decim;
    string         tag;
    q     = (sel == 0) ? exp_q2 : exp_q1;
    decim = (sel == 0) ? 2 : 1;
    tag   = (sel == 0) ? "d2" : "d1";
    full  = (q.size() == DEPTH);
    pop   = (q.size() != 0) && rdy;
    req   = vld && (ph[sel] == 0);
    if (pop) begin
      head = q.pop_front();
      check({tag, "_pop"}, 32'(obs_out), 32'(head));
    end
    if (req && (!full || pop))
      q.push_back(d);
    else if (req && drops[sel] < 255)
      drops[sel]++;
    if (vld)
      ph[sel] = (ph[sel] == decim - 1) ? 0 : ph[sel] + 1;
    if (sel == 0) exp_q2 = q;
    else          exp_q1 = q;
  endtask

  task automatic m_check(input string tag, input q_t q, input logic vld_o,
                         input logic [DW-1:0] out_o, input logic [CW-1:0] cnt_o);
    check({tag, "_cnt"},  32'(cnt_o), 32'(q.size()));
    check({tag, "_vld"},  32'(vld_o), 32'(q.size() != 0));
    check({tag, "_dout"}, 32'(out_o), (q.size() != 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic post_check();
    m_check("d2", exp_q2, bus2.Data_out_vld, bus2.Data_out, bus2.count);
    m_check("d1", exp_q1, bus1.Data_out_vld, bus1.Data_out, bus1.count);
`ifdef FIR_DECIM_OVF_EN
    check("d2_ovf", 32'(ovf2), 32'(drops[0] != 0));
    check("d2_dcnt", 32'(dc2), 32'(drops[0]));
    check("d1_ovf", 32'(ovf1), 32'(drops[1] != 0));
    check("d1_dcnt", 32'(dc1), 32'(drops[1]));
`endif
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic drive(input logic vld, input logic [DW-1:0] d, input logic rdy);
    bus2.Data_in_vld = vld; bus2.Data_in = d; bus2.Data_out_rdy = rdy;
    bus1.Data_in_vld = vld; bus1.Data_in = d; bus1.Data_out_rdy = rdy;
  endtask

  task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic rdy);
    drive(vld, d, rdy);
    m_step(0, bus2.Data_out, vld, d, rdy);
    m_step(1, bus1.Data_out, vld, d, rdy);
    @(negedge clk);
    post_check();
  endtask

  // Reset with a valid input and a ready consumer: reset must win over both.
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, DW'(99), 1'b1);
    @(negedge clk);
    exp_q2.delete();
    exp_q1.delete();
    ph[0] = 0; ph[1] = 0;
    drops[0] = 0; drops[1] = 0;
    post_check();
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    ph[0] = 0; ph[1] = 0;
    drops[0] = 0; drops[1] = 0;
    @(negedge clk);
    @(negedge clk);
    post_check();
    reset = 1'b0;

    // Continuous valid input 0..9 with ready consumer.
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b1);
    idle(3, 1'b1);

    // Fill with consumer stalled: DECIM=1 overflows by two.
    do_reset();
    for (int i = 1; i <= 10; i++) cycle(1'b1, DW'(i), 1'b0);
    check("full_cnt_d1", 32'(bus1.count), 32'd8);
    check("full_cnt_d2", 32'(bus2.count), 32'd5);
`ifdef FIR_DECIM_OVF_EN
    check("full_ovf_d1", 32'(ovf1), 32'd1);
    check("full_dcnt_d1", 32'(dc1), 32'd2);
`endif

    // Push and pop together while full.
    cycle(1'b1, DW'(11), 1'b1);
    check("fullpp_cnt_d1", 32'(bus1.count), 32'd8);
    idle(10, 1'b1);

    // Randomised push/pop traffic for pointer wrap-around.
    do_reset();
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)));
    idle(10, 1'b1);

    // Reset mid-stream with five buffered samples.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(20 + i), 1'b0);
    check("pre_rst_cnt_d1", 32'(bus1.count), 32'd5);
    do_reset();
    check("rst_cnt_d1", 32'(bus1.count), 32'd0);
    check("rst_dout_d1", 32'(bus1.Data_out), 32'd0);
    cycle(1'b1, DW'(30), 1'b0);
    check("rst_phase0_d2", 32'(bus2.count), 32'd1);
    cycle(1'b1, DW'(31), 1'b0);
    idle(4, 1'b1);

    // Ready held while empty.
    do_reset();
    idle(5, 1'b1);
    check("empty_rdy_cnt_d1", 32'(bus1.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_decim_buf.md
FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 The block SHALL have parameter DW, default 10, meaning sample width, equal to the FIR8_order Data_out width.
REQ-002 The block SHALL have parameter DECIM, default 2, meaning the decimation ratio; legal values are 1..15.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries; it SHALL be a power of two, 2..64.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port Data_in, input, DW bits: filtered sample from the upstream FIR8_order Data_out.
REQ-007 The block SHALL have port Data_in_vld, input, 1 bit: Data_in is valid this cycle.
REQ-008 The block SHALL have port Data_out, output, DW bits: head-of-FIFO sample.
REQ-009 The block SHALL have port Data_out_vld, output, 1 bit: Data_out holds a valid sample.
REQ-010 The block SHALL have port Data_out_rdy, input, 1 bit: the consumer accepts Data_out this cycle.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-012 The block SHALL hold a phase counter of 0..DECIM-1 that advances by 1 on each cycle with Data_in_vld=1 and wraps from DECIM-1 to 0.
REQ-013 The block SHALL issue a push request only on a valid cycle with phase==0; the other DECIM-1 valid samples of each group SHALL be discarded.
REQ-014 A push request SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-015 A pop SHALL occur when Data_out_vld=1 and Data_out_rdy=1.
REQ-016 Data_out_vld SHALL equal (count!=0), and Data_out SHALL equal the entry at the read pointer (first-word-fall-through).
REQ-017 Latency SHALL be 1 cycle: a sample accepted at edge k SHALL be visible on Data_out after edge k when the FIFO was empty.
REQ-018 With a simultaneous accepted push and pop, count SHALL be unchanged; with a push only, count SHALL increase by 1; with a pop only, count SHALL decrease by 1.
REQ-019 The read and write pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-020 A push request made when the FIFO is full and no pop occurs SHALL be dropped; FIFO contents and count SHALL stay unchanged, and the phase counter SHALL still advance.
REQ-021 With Data_out_rdy=1 while empty, the block SHALL NOT pop, and count SHALL stay 0.
REQ-022 With DECIM=1, every valid input SHALL be a push request.
REQ-023 Sample data SHALL pass unmodified, with no arithmetic or truncation.

Reset
REQ-024 When reset=1 at a rising clk edge, the block SHALL clear the phase counter, both pointers, count and all optional flags to 0, so that Data_out_vld=0.
REQ-025 Data_out SHALL read 0 after reset: FIFO storage is cleared, or Data_out is gated to 0 while empty.
REQ-026 Reset SHALL dominate any push or pop request in the same cycle; a reset mid-stream SHALL discard all buffered samples, and the next valid input after reset SHALL be phase 0.

Configuration
REQ-027 When macro FIR_DECIM_OVF_EN is defined, the block SHALL add output port ovf (1 bit, sticky) and output port drop_cnt (8 bits, saturating at 255).
REQ-028 Under FIR_DECIM_OVF_EN, each push dropped per REQ-020 SHALL set ovf and increment drop_cnt; only reset SHALL clear them.
REQ-029 Without FIR_DECIM_OVF_EN, the ports ovf and drop_cnt and their logic SHALL be absent, and drops SHALL be silent.

Verification
REQ-030 The bench SHALL cover: reset, then Data_in_vld=1 every cycle with Data_in=0,1,2,...,9, DECIM=2, Data_out_rdy=1 -> Data_out sequence 0,2,4,6,8, each appearing one cycle after acceptance.
REQ-031 The bench SHALL cover: DECIM=1, DEPTH=8, Data_out_rdy=0, 10 valid inputs 1..10 -> count saturates at 8, FIFO holds 1..8, 9 and 10 dropped; with FIR_DECIM_OVF_EN, ovf=1 and drop_cnt=2.
REQ-032 The bench SHALL cover: full FIFO, Data_out_rdy=1 and a push in the same cycle -> count stays 8, the new sample lands last, and the pop order is intact.
REQ-033 The bench SHALL cover: 20 push/pop cycles with DEPTH=8 -> pointer wrap-around with no data loss or duplication against a reference queue.
REQ-034 The bench SHALL cover: reset asserted with count=5 and Data_in_vld=1 -> after the edge, count=0, Data_out_vld=0, Data_out=0, ovf=0; the next input is phase 0.
REQ-035 The bench SHALL cover: Data_out_rdy held at 1 while empty for 5 cycles -> count remains 0 and no underflow occurs.
